// File: rtl/jk_excitation_driver_if.sv
// Target-word handshake and J/K excitation bundle between a stimulus source
// and jk_excitation_driver.
interface jk_excitation_driver_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             D_VALID;
  logic             D_READY;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qn;
  logic             DONE;
  logic             MISMATCH;
  logic             ERR;
  logic [CNT_W-1:0] TOG_CNT;

  modport master (
    output D_VALID, D,
    input  D_READY, J, K, Q, Qn, DONE, MISMATCH, ERR, TOG_CNT
  );

  modport slave (
    input  D_VALID, D,
    output D_READY, J, K, Q, Qn, DONE, MISMATCH, ERR, TOG_CNT
  );
endinterface

// File: rtl/jk_excitation_driver.sv
// Derives J/K excitation from a target word against the tracked JK register,
// applies it on C and self-checks that the register landed on the target.
//
//   state   | meaning
//   S_IDLE  | ready for a target; J=K=0; accept edge registers excitation
//   S_APPLY | J/K driven; this edge clocks the JK register and toggle count
//   S_CHECK | DONE high; MISMATCH valid; this edge folds MISMATCH into ERR
module jk_excitation_driver #(
  parameter int WIDTH    = 4,
  parameter int DC_VALUE = 0,
  parameter int CNT_W    = 8
) (
  input logic                  C,
  input logic                  RST,
  jk_excitation_driver_if.slave bus
);

  localparam int POP_W = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});
  localparam logic [WIDTH-1:0] DC_VEC  = {WIDTH{DC_VALUE != 0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] q_q,      q_d;
  logic [WIDTH-1:0] j_q,      j_d;
  logic [WIDTH-1:0] k_q,      k_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             ready_q,  ready_d;
  logic             done_q,   done_d;
  logic             err_q,    err_d;
  logic [CNT_W-1:0] tog_q,    tog_d;

  logic             mismatch;
  logic [WIDTH-1:0] j_exc;
  logic [WIDTH-1:0] k_exc;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] toggle_bits;
  logic [SUM_W-1:0] tog_pop;
  logic [SUM_W-1:0] tog_sum;

  // Excitation table folded into boolean form: J only matters where Q=0,
  // K only where Q=1; the other input takes the don't-care value.
  always_comb begin
    j_exc = (~q_q & bus.D) | (q_q & DC_VEC);
    k_exc = (q_q & ~bus.D) | (~q_q & DC_VEC);
  end

  always_comb begin
    q_next      = (j_q & ~q_q) | (~k_q & q_q);
    toggle_bits = j_q & k_q;
    tog_pop     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      tog_pop = tog_pop + SUM_W'(toggle_bits[i]);
    end
    tog_sum  = SUM_W'(tog_q) + tog_pop;
    mismatch = (state_q == S_CHECK) && (q_q != target_q);
  end

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    j_d      = j_q;
    k_d      = k_q;
    target_d = target_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    err_d    = err_q;
    tog_d    = tog_q;

    case (state_q)
      S_IDLE: begin
        if (bus.D_VALID && ready_q) begin
          target_d = bus.D;
          j_d      = j_exc;
          k_d      = k_exc;
          ready_d  = 1'b0;
          state_d  = S_APPLY;
        end
      end
      S_APPLY: begin
        q_d     = q_next;
        tog_d   = (tog_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : tog_sum[CNT_W-1:0];
        done_d  = 1'b1;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        err_d   = err_q | mismatch;
        j_d     = '0;
        k_d     = '0;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        j_d     = '0;
        k_d     = '0;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge C or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      q_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      target_q <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tog_q    <= '0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      j_q      <= j_d;
      k_q      <= k_d;
      target_q <= target_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      err_q    <= err_d;
      tog_q    <= tog_d;
    end
  end

  assign bus.D_READY  = ready_q;
  assign bus.J        = j_q;
  assign bus.K        = k_q;
  assign bus.Q        = q_q;
  assign bus.Qn       = ~q_q;
  assign bus.DONE     = done_q;
  assign bus.MISMATCH = mismatch;
  assign bus.ERR      = err_q;
  assign bus.TOG_CNT  = tog_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Drives three driver instances (DC_VALUE 0/1, CNT_W 8/2) in lockstep and
// compares them against a transaction-level excitation-table model.
module tb_jk_excitation_driver;
  localparam int W  = 4;
  localparam int NU = 3;

  logic C   = 1'b0;
  logic RST = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 C = ~C;

  jk_excitation_driver_if #(.WIDTH(W), .CNT_W(8)) b0 ();
  jk_excitation_driver_if #(.WIDTH(W), .CNT_W(8)) b1 ();
  jk_excitation_driver_if #(.WIDTH(W), .CNT_W(2)) b2 ();

  jk_excitation_driver #(.WIDTH(W), .DC_VALUE(0), .CNT_W(8)) u0 (.C(C), .RST(RST), .bus(b0));
  jk_excitation_driver #(.WIDTH(W), .DC_VALUE(1), .CNT_W(8)) u1 (.C(C), .RST(RST), .bus(b1));
  jk_excitation_driver #(.WIDTH(W), .DC_VALUE(1), .CNT_W(2)) u2 (.C(C), .RST(RST), .bus(b2));

  logic [W-1:0] j_o [NU];
  logic [W-1:0] k_o [NU];
  logic [W-1:0] q_o [NU];
  logic [W-1:0] qn_o[NU];
  logic         rdy_o [NU];
  logic         done_o[NU];
  logic         mm_o  [NU];
  logic         err_o [NU];
  logic [7:0]   tog_o [NU];

  assign j_o[0] = b0.J;   assign j_o[1] = b1.J;   assign j_o[2] = b2.J;
  assign k_o[0] = b0.K;   assign k_o[1] = b1.K;   assign k_o[2] = b2.K;
  assign q_o[0] = b0.Q;   assign q_o[1] = b1.Q;   assign q_o[2] = b2.Q;
  assign qn_o[0] = b0.Qn; assign qn_o[1] = b1.Qn; assign qn_o[2] = b2.Qn;
  assign rdy_o[0] = b0.D_READY; assign rdy_o[1] = b1.D_READY; assign rdy_o[2] = b2.D_READY;
  assign done_o[0] = b0.DONE;   assign done_o[1] = b1.DONE;   assign done_o[2] = b2.DONE;
  assign mm_o[0] = b0.MISMATCH; assign mm_o[1] = b1.MISMATCH; assign mm_o[2] = b2.MISMATCH;
  assign err_o[0] = b0.ERR;     assign err_o[1] = b1.ERR;     assign err_o[2] = b2.ERR;
  assign tog_o[0] = b0.TOG_CNT; assign tog_o[1] = b1.TOG_CNT; assign tog_o[2] = {6'd0, b2.TOG_CNT};

  // Reference model: present state and toggle totals at transaction level.
  logic [W-1:0] mq;
  int           mtog[NU];

  function automatic int dc_of(input int u);
    return (u == 0) ? 0 : 1;
  endfunction

  function automatic int tmax_of(input int u);
    return (u == 2) ? 3 : 255;
  endfunction

  // JK excitation table indexed by {present, next}; 2 marks a don't-care.
  function automatic int j_tbl(input int qd);
    case (qd)
      0: return 0;
      1: return 1;
      default: return 2;
    endcase
  endfunction

  function automatic int k_tbl(input int qd);
    case (qd)
      2: return 1;
      3: return 0;
      default: return 2;
    endcase
  endfunction

  function automatic void exc(input logic [W-1:0] q, input logic [W-1:0] d, input int dc,
                              output logic [W-1:0] j, output logic [W-1:0] k);
    for (int i = 0; i < W; i++) begin
      int qd, jv, kv;
      qd   = (q[i] ? 2 : 0) + (d[i] ? 1 : 0);
      jv   = j_tbl(qd);
      kv   = k_tbl(qd);
      j[i] = (jv == 2) ? (dc != 0) : (jv == 1);
      k[i] = (kv == 2) ? (dc != 0) : (kv == 1);
    end
  endfunction

  function automatic void model_apply(input logic [W-1:0] d);
    logic [W-1:0] ej, ek;
    int t;
    for (int u = 0; u < NU; u++) begin
      exc(mq, d, dc_of(u), ej, ek);
      t = mtog[u] + $countones(ej & ek);
      mtog[u] = (t > tmax_of(u)) ? tmax_of(u) : t;
    end
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] d);
    b0.D_VALID = v; b0.D = d;
    b1.D_VALID = v; b1.D = d;
    b2.D_VALID = v; b2.D = d;
  endtask

  task automatic step();
    @(posedge C);
    #1;
  endtask

  task automatic test_reset();
    for (int pass = 0; pass < 2; pass++) begin
      for (int u = 0; u < NU; u++) begin
        vectors++;
        if (q_o[u] !== 4'h0 || qn_o[u] !== 4'hF || j_o[u] !== 4'h0 || k_o[u] !== 4'h0 ||
            rdy_o[u] !== 1'b1 || done_o[u] !== 1'b0 || mm_o[u] !== 1'b0 ||
            err_o[u] !== 1'b0 || tog_o[u] !== 8'd0) begin
          miscompares++;
          $display("FAIL reset pass%0d u%0d: got q=%h qn=%h j=%h k=%h rdy=%b done=%b mm=%b err=%b tog=%0d, want q=0 qn=f j=0 k=0 rdy=1 done=0 mm=0 err=0 tog=0",
                   pass, u, q_o[u], qn_o[u], j_o[u], k_o[u], rdy_o[u], done_o[u], mm_o[u], err_o[u], tog_o[u]);
        end
      end
      if (pass == 0) begin
        @(negedge C);
        RST = 1'b0;
        step();
      end
    end
    mq = '0;
    for (int u = 0; u < NU; u++) mtog[u] = 0;
  endtask

  task automatic test_directed();
    logic [W-1:0] words[6] = '{4'b1010, 4'b0110, 4'b0110, 4'b0000, 4'b1111, 4'b0000};
    for (int n = 0; n < 6; n++) begin
      logic [W-1:0] d, ej, ek;
      d = words[n];
      vectors++;
      if (rdy_o[0] !== 1'b1) begin
        miscompares++;
        $display("FAIL dir_ready w%0d: got %b want 1", n, rdy_o[0]);
      end
      drive(1'b1, d);
      step();
      drive(1'b0, '0);
      for (int u = 0; u < NU; u++) begin
        exc(mq, d, dc_of(u), ej, ek);
        vectors++;
        if (j_o[u] !== ej || k_o[u] !== ek || rdy_o[u] !== 1'b0 || done_o[u] !== 1'b0) begin
          miscompares++;
          $display("FAIL dir_apply w%0d u%0d: got j=%b k=%b rdy=%b done=%b, want j=%b k=%b rdy=0 done=0",
                   n, u, j_o[u], k_o[u], rdy_o[u], done_o[u], ej, ek);
        end
      end
      model_apply(d);
      step();
      for (int u = 0; u < NU; u++) begin
        vectors++;
        if (q_o[u] !== d || qn_o[u] !== ~d || done_o[u] !== 1'b1 || mm_o[u] !== 1'b0 ||
            rdy_o[u] !== 1'b0 || tog_o[u] !== 8'(mtog[u])) begin
          miscompares++;
          $display("FAIL dir_check w%0d u%0d: got q=%b qn=%b done=%b mm=%b rdy=%b tog=%0d, want q=%b qn=%b done=1 mm=0 rdy=0 tog=%0d",
                   n, u, q_o[u], qn_o[u], done_o[u], mm_o[u], rdy_o[u], tog_o[u], d, ~d, mtog[u]);
        end
      end
      step();
      for (int u = 0; u < NU; u++) begin
        vectors++;
        if (j_o[u] !== 4'h0 || k_o[u] !== 4'h0 || rdy_o[u] !== 1'b1 || done_o[u] !== 1'b0 ||
            err_o[u] !== 1'b0 || q_o[u] !== d) begin
          miscompares++;
          $display("FAIL dir_idle w%0d u%0d: got j=%b k=%b rdy=%b done=%b err=%b q=%b, want j=0 k=0 rdy=1 done=0 err=0 q=%b",
                   n, u, j_o[u], k_o[u], rdy_o[u], done_o[u], err_o[u], q_o[u], d);
        end
      end
      mq = d;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic [W-1:0] d, ej, ek;
      d = W'($urandom_range(0, 15));
      drive(1'b1, d);
      step();
      drive(1'b0, W'($urandom_range(0, 15)));
      for (int u = 0; u < NU; u++) begin
        exc(mq, d, dc_of(u), ej, ek);
        vectors++;
        if (j_o[u] !== ej || k_o[u] !== ek) begin
          miscompares++;
          $display("FAIL rnd_jk n%0d u%0d q=%b d=%b: got j=%b k=%b want j=%b k=%b",
                   n, u, mq, d, j_o[u], k_o[u], ej, ek);
        end
      end
      model_apply(d);
      step();
      for (int u = 0; u < NU; u++) begin
        vectors++;
        if (q_o[u] !== d || done_o[u] !== 1'b1 || mm_o[u] !== 1'b0 || tog_o[u] !== 8'(mtog[u])) begin
          miscompares++;
          $display("FAIL rnd_q n%0d u%0d: got q=%b done=%b mm=%b tog=%0d, want q=%b done=1 mm=0 tog=%0d",
                   n, u, q_o[u], done_o[u], mm_o[u], tog_o[u], d, mtog[u]);
        end
      end
      step();
      mq = d;
    end
    for (int u = 0; u < NU; u++) begin
      vectors++;
      if (err_o[u] !== 1'b0 || rdy_o[u] !== 1'b1) begin
        miscompares++;
        $display("FAIL rnd_end u%0d: got err=%b rdy=%b want err=0 rdy=1", u, err_o[u], rdy_o[u]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words[3] = '{4'b0001, 4'b0010, 4'b0100};
    logic [W-1:0] ej, ek;
    int dones = 0;
    drive(1'b1, words[0]);
    for (int c = 0; c < 9; c++) begin
      int w;
      w = c / 3;
      step();
      if (done_o[0] === 1'b1) dones++;
      case (c % 3)
        0: begin
          exc(mq, words[w], 0, ej, ek);
          vectors++;
          if (j_o[0] !== ej || k_o[0] !== ek || rdy_o[0] !== 1'b0 || done_o[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_accept c%0d: got j=%b k=%b rdy=%b done=%b, want j=%b k=%b rdy=0 done=0",
                     c, j_o[0], k_o[0], rdy_o[0], done_o[0], ej, ek);
          end
          model_apply(words[w]);
          if (w < 2) drive(1'b1, words[w+1]);
          else       drive(1'b0, '0);
        end
        1: begin
          for (int u = 0; u < NU; u++) begin
            vectors++;
            if (q_o[u] !== words[w] || done_o[u] !== 1'b1 || rdy_o[u] !== 1'b0 ||
                mm_o[u] !== 1'b0 || tog_o[u] !== 8'(mtog[u])) begin
              miscompares++;
              $display("FAIL b2b_check c%0d u%0d: got q=%b done=%b rdy=%b mm=%b tog=%0d, want q=%b done=1 rdy=0 mm=0 tog=%0d",
                       c, u, q_o[u], done_o[u], rdy_o[u], mm_o[u], tog_o[u], words[w], mtog[u]);
            end
          end
        end
        default: begin
          vectors++;
          if (rdy_o[0] !== 1'b1 || done_o[0] !== 1'b0 || err_o[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle c%0d: got rdy=%b done=%b err=%b want rdy=1 done=0 err=0",
                     c, rdy_o[0], done_o[0], err_o[0]);
          end
          mq = words[w];
        end
      endcase
    end
    vectors++;
    if (dones != 3) begin
      miscompares++;
      $display("FAIL b2b_done_count: got %0d want 3", dones);
    end
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    drive(1'b1, 4'b1111);
    step();
    drive(1'b0, '0);
    #2 RST = 1'b1;
    #1;
    for (int u = 0; u < NU; u++) begin
      vectors++;
      if (q_o[u] !== 4'h0 || qn_o[u] !== 4'hF || j_o[u] !== 4'h0 || k_o[u] !== 4'h0 ||
          rdy_o[u] !== 1'b1 || done_o[u] !== 1'b0 || err_o[u] !== 1'b0 || tog_o[u] !== 8'd0) begin
        miscompares++;
        $display("FAIL abort_rst u%0d: got q=%h qn=%h j=%h k=%h rdy=%b done=%b err=%b tog=%0d, want q=0 qn=f j=0 k=0 rdy=1 done=0 err=0 tog=0",
                 u, q_o[u], qn_o[u], j_o[u], k_o[u], rdy_o[u], done_o[u], err_o[u], tog_o[u]);
      end
    end
    @(negedge C);
    RST = 1'b0;
    mq = '0;
    for (int u = 0; u < NU; u++) mtog[u] = 0;
    repeat (3) begin
      step();
      if (done_o[0] === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0 || q_o[0] !== 4'h0 || rdy_o[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_quiet: got dones=%0d q=%b rdy=%b want dones=0 q=0000 rdy=1",
               dones, q_o[0], rdy_o[0]);
    end
    drive(1'b1, 4'b0101);
    step();
    drive(1'b0, '0);
    model_apply(4'b0101);
    step();
    for (int u = 0; u < NU; u++) begin
      vectors++;
      if (q_o[u] !== 4'b0101 || done_o[u] !== 1'b1 || mm_o[u] !== 1'b0 || tog_o[u] !== 8'(mtog[u])) begin
        miscompares++;
        $display("FAIL abort_next u%0d: got q=%b done=%b mm=%b tog=%0d, want q=0101 done=1 mm=0 tog=%0d",
                 u, q_o[u], done_o[u], mm_o[u], tog_o[u], mtog[u]);
      end
    end
    step();
    mq = 4'b0101;
  endtask

  initial begin
    drive(1'b0, '0);
    repeat (2) step();
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
